// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//   Sequences a full PLL reconfiguration through an ALTPLL_RECONFIG-style
//   parameter port. On trigger it shadows N, M and C0..C(NUM_CNT-1). For each
//   counter it writes the bypass bit, plus the nominal count when the factor
//   is greater than 1. It then issues reconfig and supervises lock with a
//   timeout, areset retries and a sticky error.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   trigger             start request (only honoured in IDLE)
//   cfg_n/cfg_m/cfg_c   factors; cfg_c packs C0 in [7:0]
//   locked, rcfg_busy   PLL lock and pllrcfg busy inputs
//   busy/done/error     sequence status (error is sticky until next trigger)
//   counter_type/counter_param/data_in/write_param  parameter write port
//   reconfig            reconfigure strobe
//   pll_areset_in       PLL areset request during retry
module pll_reconfig_seq #(
  parameter int NUM_CNT       = 1,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int LOCK_STABLE   = 16,
  parameter int ARESET_CYCLES = 8,
  parameter int MAX_RETRY     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [7:0]           cfg_n,
  input  logic [7:0]           cfg_m,
  input  logic [8*NUM_CNT-1:0] cfg_c,
  input  logic                 locked,
  input  logic                 rcfg_busy,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [3:0]           counter_type,
  output logic [2:0]           counter_param,
  output logic [8:0]           data_in,
  output logic                 write_param,
  output logic                 reconfig,
  output logic                 pll_areset_in
);

  localparam int NFAC = NUM_CNT + 2;
  localparam int IW   = $clog2(NFAC);
  localparam int TMAX = (LOCK_TIMEOUT > ARESET_CYCLES) ? LOCK_TIMEOUT : ARESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(LOCK_STABLE + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE, CHECK, WR, WR_GAP, WR_WAIT, RCFG, RC_GAP, RC_WAIT,
    LOCK, ARST, DONE, ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [NFAC-1:0][7:0]  fac_q;     // [0]=N, [1]=M, [2+i]=Ci
  logic [IW-1:0]         idx_q, idx_d;
  logic                  nom_q, nom_d; // 0: bypass write, 1: nominal write
  logic [TW-1:0]         tmr_q;     // cycles spent in current state
  logic [SW-1:0]         stab_q;
  logic [RW-1:0]         retry_q;
  logic                  error_q;
  logic [7:0]            fac_cur;
  logic                  any_zero;
  logic                  in_wr;

  assign fac_cur = fac_q[idx_q];

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < NFAC; k++)
      if (fac_q[k] == 8'd0) any_zero = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nom_d   = nom_q;
    case (state_q)
      IDLE:    if (trigger) state_d = CHECK;
      CHECK: begin
        if (any_zero) state_d = ERROR;
        else begin
          state_d = WR;
          idx_d   = '0;
          nom_d   = 1'b0;
        end
      end
      WR:      state_d = WR_GAP;
      WR_GAP:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (!rcfg_busy) begin
          if (!nom_q && fac_cur > 8'd1) begin
            nom_d   = 1'b1;
            state_d = WR;
          end else if (idx_q == IW'(NFAC - 1)) begin
            state_d = RCFG;
          end else begin
            idx_d   = idx_q + 1'b1;
            nom_d   = 1'b0;
            state_d = WR;
          end
        end
      end
      RCFG:    state_d = RC_GAP;
      RC_GAP:  state_d = RC_WAIT;
      RC_WAIT: if (!rcfg_busy) state_d = LOCK;
      LOCK: begin
        // Stable lock is checked first so it wins over a coincident timeout.
        if (locked && stab_q == SW'(LOCK_STABLE - 1))
          state_d = DONE;
        else if (tmr_q == TW'(LOCK_TIMEOUT - 1))
          state_d = (retry_q < RW'(MAX_RETRY)) ? ARST : ERROR;
      end
      ARST:    if (tmr_q == TW'(ARESET_CYCLES - 1)) state_d = LOCK;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nom_q   <= 1'b0;
      fac_q   <= '0;
      tmr_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nom_q   <= nom_d;
      if (state_q == IDLE && trigger) begin
        fac_q   <= {cfg_c, cfg_m, cfg_n};
        error_q <= 1'b0;
        retry_q <= '0;
      end
      if (state_d == ERROR) error_q <= 1'b1;
      // Timer restarts on every state change, so LOCK after ARST starts fresh.
      tmr_q  <= (state_d != state_q) ? '0 : tmr_q + 1'b1;
      stab_q <= (state_q == LOCK && state_d == LOCK && locked) ? stab_q + 1'b1 : '0;
      if (state_q == LOCK && state_d == ARST) retry_q <= retry_q + 1'b1;
    end
  end

  assign in_wr         = (state_q == WR) || (state_q == WR_GAP) || (state_q == WR_WAIT);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign write_param   = (state_q == WR);
  assign reconfig      = (state_q == RCFG);
  assign pll_areset_in = (state_q == ARST);

  // Write-port fields derive from idx/nom, which only change on WR_WAIT exit.
  always_comb begin
    counter_type  = 4'd0;
    counter_param = 3'b000;
    data_in       = 9'd0;
    if (in_wr) begin
      counter_type  = (idx_q < IW'(2)) ? 4'(idx_q) : 4'(idx_q) + 4'd2;
      counter_param = nom_q ? 3'b111 : 3'b100;
      data_in       = nom_q ? {1'b0, fac_cur} : {8'd0, fac_cur == 8'd1};
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench: stimulus pushes expected events per instance; negedge
// monitors pop and compare whenever a DUT strobe/status event appears.
// Instance A: NUM_CNT=1, LOCK_TIMEOUT=200. Instance B: NUM_CNT=3, LOCK_TIMEOUT=50.
module tb_pll_reconfig_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  localparam int K_WR = 1, K_RC = 2, K_DN = 3, K_ER = 4, K_AR = 5;
  typedef struct {
    int kind;
    int ctype;
    int cparam;
    int data;
    int at;
  } ev_t;
  ev_t qa[$];
  ev_t qb[$];

  logic        rst_a, trig_a, lk_a, rb_a;
  logic [7:0]  n_a, m_a, c_a;
  logic        bz_a, dn_a, er_a, wp_a, rc_a, ar_a;
  logic [3:0]  ct_a;
  logic [2:0]  cp_a;
  logic [8:0]  di_a;

  logic        rst_b, trig_b, lk_b, rb_b;
  logic [7:0]  n_b, m_b;
  logic [23:0] c_b;
  logic        bz_b, dn_b, er_b, wp_b, rc_b, ar_b;
  logic [3:0]  ct_b;
  logic [2:0]  cp_b;
  logic [8:0]  di_b;

  pll_reconfig_seq #(.NUM_CNT(1), .LOCK_TIMEOUT(200), .LOCK_STABLE(16),
                     .ARESET_CYCLES(8), .MAX_RETRY(1)) u_a (
    .clock(clk), .reset(rst_a), .trigger(trig_a), .cfg_n(n_a), .cfg_m(m_a),
    .cfg_c(c_a), .locked(lk_a), .rcfg_busy(rb_a), .busy(bz_a), .done(dn_a),
    .error(er_a), .counter_type(ct_a), .counter_param(cp_a), .data_in(di_a),
    .write_param(wp_a), .reconfig(rc_a), .pll_areset_in(ar_a));

  pll_reconfig_seq #(.NUM_CNT(3), .LOCK_TIMEOUT(50), .LOCK_STABLE(16),
                     .ARESET_CYCLES(8), .MAX_RETRY(1)) u_b (
    .clock(clk), .reset(rst_b), .trigger(trig_b), .cfg_n(n_b), .cfg_m(m_b),
    .cfg_c(c_b), .locked(lk_b), .rcfg_busy(rb_b), .busy(bz_b), .done(dn_b),
    .error(er_b), .counter_type(ct_b), .counter_param(cp_b), .data_in(di_b),
    .write_param(wp_b), .reconfig(rc_b), .pll_areset_in(ar_b));

  // pllrcfg model: busy for 4 cycles after each write/reconfig strobe
  int bc_a = 0, bc_b = 0;
  always @(posedge clk) begin
    if (wp_a || rc_a) bc_a <= 4; else if (bc_a > 0) bc_a <= bc_a - 1;
    if (wp_b || rc_b) bc_b <= 4; else if (bc_b > 0) bc_b <= bc_b - 1;
  end
  assign rb_a = (bc_a != 0);
  assign rb_b = (bc_b != 0);

  task automatic push(input int id, input int kind, input int t, input int p,
                      input int d, input int at);
    ev_t e;
    e.kind = kind; e.ctype = t; e.cparam = p; e.data = d; e.at = at;
    if (id == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic sb(input int id, input int kind, input int t, input int p, input int d);
    ev_t e;
    bit  got;
    got = 1'b0;
    n_vec++;
    if (id == 0 && qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
    if (id == 1 && qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
    if (!got) begin
      n_bad++;
      $display("FAIL sb%0d unexpected event kind=%0d type=%0d param=%0b data=%0d cyc=%0d",
               id, kind, t, p, d, cyc);
    end else if (e.kind != kind || e.ctype != t || e.cparam != p || e.data != d ||
                 (e.at >= 0 && e.at != cyc)) begin
      n_bad++;
      $display("FAIL sb%0d event got kind=%0d type=%0d param=%0b data=%0d cyc=%0d want kind=%0d type=%0d param=%0b data=%0d cyc=%0d",
               id, kind, t, p, d, cyc, e.kind, e.ctype, e.cparam, e.data, e.at);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Monitors
  logic er_pa = 1'b0, er_pb = 1'b0;
  int   arl_a = 0, arl_b = 0;
  always @(negedge clk) begin
    if (wp_a) sb(0, K_WR, int'(ct_a), int'(cp_a), int'(di_a));
    if (rc_a) sb(0, K_RC, 0, 0, 0);
    if (dn_a) sb(0, K_DN, 0, 0, 0);
    if (er_a && !er_pa) sb(0, K_ER, 0, 0, 0);
    if (ar_a) arl_a++;
    else if (arl_a > 0) begin sb(0, K_AR, 0, 0, arl_a); arl_a = 0; end
    er_pa = er_a;
    if (wp_b) sb(1, K_WR, int'(ct_b), int'(cp_b), int'(di_b));
    if (rc_b) sb(1, K_RC, 0, 0, 0);
    if (dn_b) sb(1, K_DN, 0, 0, 0);
    if (er_b && !er_pb) sb(1, K_ER, 0, 0, 0);
    if (ar_b) arl_b++;
    else if (arl_b > 0) begin sb(1, K_AR, 0, 0, arl_b); arl_b = 0; end
    er_pb = er_b;
  end

  // what: 0 rc_a, 1 wp_a, 2 A idle, 3 rc_b, 4 B idle
  task automatic wait_ev(input int what, input int budget);
    bit ok;
    bit c;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (what)
        0: c = rc_a;
        1: c = wp_a;
        2: c = !bz_a;
        3: c = rc_b;
        default: c = !bz_b;
      endcase
      if (c) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_ev%0d timed out after %0d cycles", what, budget);
    end
  endtask

  task automatic trig(input int id, output int t0);
    @(posedge clk); #1;
    if (id == 0) trig_a = 1'b1; else trig_b = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    trig_a = 1'b0;
    trig_b = 1'b0;
  endtask

  // N=1, M=8, C0=4
  task automatic push_basic_a();
    push(0, K_WR, 4'b0000, 3'b100, 1, -1);
    push(0, K_WR, 4'b0001, 3'b100, 0, -1);
    push(0, K_WR, 4'b0001, 3'b111, 8, -1);
    push(0, K_WR, 4'b0100, 3'b100, 0, -1);
    push(0, K_WR, 4'b0100, 3'b111, 4, -1);
    push(0, K_RC, 0, 0, 0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    rst_a = 1'b1; trig_a = 1'b0; lk_a = 1'b0; n_a = 8'd1; m_a = 8'd8; c_a = 8'd4;
    rst_b = 1'b1; trig_b = 1'b0; lk_b = 1'b0; n_b = 8'd2; m_b = 8'd3; c_b = 24'h030201;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_a", int'({bz_a, dn_a, er_a, wp_a, rc_a, ar_a, ct_a, cp_a, di_a}), 0);
    chk("reset_outs_b", int'({bz_b, dn_b, er_b, wp_b, rc_b, ar_b, ct_b, cp_b, di_b}), 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Bad factor: M=0 -> error two cycles after trigger, no writes
    m_a = 8'd0;
    trig(0, t0);
    push(0, K_ER, 0, 0, 0, t0 + 2);
    wait_ev(2, 20);
    chk("bad_error_sticky", int'(er_a), 1);
    chk("bad_busy_low", int'(bz_a), 0);
    chk("bad_queue_drained", qa.size(), 0);

    // Basic sequence, lock 100 cycles after reconfig
    m_a = 8'd8;
    push_basic_a();
    trig(0, t0);
    @(negedge clk);
    chk("basic_error_cleared", int'(er_a), 0);
    chk("basic_busy_high", int'(bz_a), 1);
    wait_ev(0, 300);
    repeat (100) @(posedge clk);
    #1 lk_a = 1'b1;
    push(0, K_DN, 0, 0, 0, cyc + 16);
    wait_ev(2, 100);
    chk("basic_error_low", int'(er_a), 0);
    chk("basic_queue_drained", qa.size(), 0);

    // Glitching lock: 10-cycle high windows never reach 16 stable cycles
    lk_a = 1'b0;
    push_basic_a();
    trig(0, t0);
    wait_ev(0, 300);
    for (int i = 0; i < 12; i++) begin
      repeat (10) @(posedge clk);
      #1 lk_a = ~lk_a;
    end
    repeat (10) @(posedge clk);
    #1 lk_a = 1'b1;
    push(0, K_DN, 0, 0, 0, cyc + 16);
    wait_ev(2, 100);
    chk("glitch_queue_drained", qa.size(), 0);

    // Reset in WR_WAIT after the N bypass write, then a clean restart
    lk_a = 1'b0;
    push(0, K_WR, 4'b0000, 3'b100, 1, -1);
    trig(0, t0);
    wait_ev(1, 50);
    @(posedge clk);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("midrst_outs", int'({bz_a, dn_a, er_a, wp_a, rc_a, ar_a, ct_a, cp_a, di_a}), 0);
    chk("midrst_queue", qa.size(), 0);
    lk_a = 1'b1;
    push_basic_a();
    push(0, K_DN, 0, 0, 0, -1);
    trig(0, t0);
    wait_ev(2, 300);
    chk("restart_queue_drained", qa.size(), 0);

    // NUM_CNT=3, N=2 M=3 C=1,2,3, ignored triggers, lock never comes
    push(1, K_WR, 4'b0000, 3'b100, 0, -1);
    push(1, K_WR, 4'b0000, 3'b111, 2, -1);
    push(1, K_WR, 4'b0001, 3'b100, 0, -1);
    push(1, K_WR, 4'b0001, 3'b111, 3, -1);
    push(1, K_WR, 4'b0100, 3'b100, 1, -1);
    push(1, K_WR, 4'b0101, 3'b100, 0, -1);
    push(1, K_WR, 4'b0101, 3'b111, 2, -1);
    push(1, K_WR, 4'b0110, 3'b100, 0, -1);
    push(1, K_WR, 4'b0110, 3'b111, 3, -1);
    push(1, K_RC, 0, 0, 0, -1);
    push(1, K_AR, 0, 0, 8, -1);
    push(1, K_ER, 0, 0, 0, -1);
    trig(1, t0);
    n_b = 8'd0; m_b = 8'd0; c_b = 24'd0;
    for (int i = 0; i < 3; i++) begin
      repeat (7) @(posedge clk);
      #1 trig_b = 1'b1;
      @(posedge clk);
      #1 trig_b = 1'b0;
    end
    wait_ev(4, 2000);
    chk("b_error_set", int'(er_b), 1);
    chk("b_queue_drained", qb.size(), 0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Parametrised PLL reconfiguration sequencer; successor to the fixed single-output M/N reconfiguration controller. On a trigger it latches N, M and NUM_CNT post-scale output divider values. It writes each value through the ALTPLL_RECONFIG-style parameter port, then issues a reconfigure and supervises lock with timeout, areset retry and a sticky error. It sits between the test-controller register file and the pllrcfg megafunction driving the tester's DUT clock PLL.

## Interface

Parameters:
- NUM_CNT, 1, number of post-scale counters C0..C(NUM_CNT-1), 1..5
- LOCK_TIMEOUT, 65535, cycles to wait for stable lock before areset/retry
- LOCK_STABLE, 16, consecutive locked-high cycles required to declare lock
- ARESET_CYCLES, 8, width of pll_areset_in pulse on retry
- MAX_RETRY, 1, areset retries after first timeout before error

Ports:
- clock  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- trigger  in  1  start request, sampled in IDLE only
- cfg_n  in  8  pre-scale N factor
- cfg_m  in  8  feedback M factor
- cfg_c  in  8*NUM_CNT  post-scale factors; C0 in bits [7:0]
- locked  in  1  PLL lock indicator (already synchronised)
- rcfg_busy  in  1  busy from pllrcfg block
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful lock
- error  out  1  sticky; set on bad factor or final timeout, cleared by next accepted trigger
- counter_type  out  4  0000 N, 0001 M, 0100+i Ci
- counter_param  out  3  100 bypass, 111 nominal count
- data_in  out  9  write value, zero-extended factor
- write_param  out  1  one-cycle write strobe
- reconfig  out  1  one-cycle reconfigure strobe
- pll_areset_in  out  1  PLL areset request

## Operation

- Counter order: N, M, C0..C(NUM_CNT-1); index width clog2(NUM_CNT+2).
- On accepted trigger (IDLE, trigger=1):
  - Latch all factors into an internal shadow copy.
  - Clear error and the retry count; assert busy.
- Factor 0 anywhere: go straight to ERROR. No writes are issued.
- Per counter, factor f:
  - Write bypass (param 100, data = (f==1)).
  - If f>1, also write nominal (param 111, data = {1'b0,f}).
- States:
  - IDLE
  - CHECK: validate factors, 1 cycle
  - WR: write_param=1, 1 cycle
  - WR_GAP: 1 cycle, ignores rcfg_busy
  - WR_WAIT: until rcfg_busy=0, then next write or RCFG
  - RCFG: reconfig=1, 1 cycle
  - RC_GAP: 1 cycle
  - RC_WAIT: until rcfg_busy=0
  - LOCK: count consecutive locked=1 and a timeout counter
  - ARST: pll_areset_in=1 for ARESET_CYCLES
  - DONE: done=1, 1 cycle, then IDLE
  - ERROR: error set, 1 cycle, then IDLE
- LOCK state:
  - locked=0 resets the stable counter.
  - Stable counter reaching LOCK_STABLE goes to DONE.
  - Timeout counter reaching LOCK_TIMEOUT goes to ARST if retries < MAX_RETRY (retry count increments), else ERROR.
  - ARST returns to LOCK with both counters cleared.
- Retry only re-locks. The scan chain is not rewritten.
- Trigger outside IDLE is ignored; factor inputs may change freely after acceptance.

## Timing

- Reset values:
  - busy, done, error, write_param, reconfig, pll_areset_in = 0
  - counter_type, counter_param, data_in = 0
  - FSM in IDLE
- Reset mid-sequence aborts in the next cycle, with no further strobes. Reset during ARST deasserts pll_areset_in.
- busy rises the cycle after the accepted trigger. It stays high through the DONE/ERROR cycle and is low in IDLE.
- counter_type, counter_param and data_in are valid in the WR cycle and held until WR_WAIT exits.
- Minimum write spacing: 3 cycles (WR, WR_GAP, one WR_WAIT with rcfg_busy=0).
- rcfg_busy high in WR_GAP is ignored. rcfg_busy already 0 in the first WR_WAIT cycle advances immediately.
- Lock latency: DONE at the earliest LOCK_STABLE cycles after entering LOCK.
- Simultaneous events in LOCK: stable-count reached and timeout in the same cycle → DONE wins.
- Write count: sum over counters of (1 + (f>1)). Example: N=1, M=8, C0=4 gives 5 writes.

## Test plan

- Basic sequence, NUM_CNT=1, factors N=1, M=8, C0=4; rcfg_busy model high 4 cycles after each strobe; locked rises 100 cycles after reconfig:
  - Exactly 5 write_param pulses, in this order:
    - (0000,100,1)
    - (0001,100,0), (0001,111,8)
    - (0100,100,0), (0100,111,4)
  - Then one reconfig pulse.
  - done pulses LOCK_STABLE cycles after locked rises; error=0.
- Bad factor, cfg_m=0: error=1 within 3 cycles; no write_param or reconfig; busy back to 0.
- Lock failure, locked held 0, LOCK_TIMEOUT=50, MAX_RETRY=1:
  - One 8-cycle pll_areset_in pulse.
  - error set after the second timeout; no done.
- Glitching lock, locked toggling every 10 cycles, LOCK_STABLE=16: never done; once held high, done after 16 cycles.
- Reset asserted mid WR_WAIT:
  - All outputs 0 next cycle.
  - A fresh trigger restarts from the N bypass write.
- NUM_CNT=3 with C values 1, 2, 3 and trigger pulses during busy:
  - Ignored triggers; writes to types 0100, 0101, 0110.
  - C0 gets a bypass write only.
